// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared FSM state type and default sizing for the data memory.
package data_memory_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_INIT0  = 53;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;
endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: combinational byte-lane merge of write data into an existing word.
module dm_byte_merge #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   new_o
);
    for (genvar g = 0; g < DATA_W / 8; g++) begin : g_lane
        assign new_o[8*g+:8] = be_i[g] ? wdata_i[8*g+:8] : old_i[8*g+:8];
    end
endmodule

// File: rtl/data_memory_param.sv
// data_memory_param: byte-writable word memory with registered reads and a
// self-clearing sweep that runs after reset and on request.
module data_memory_param
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INIT0  = DEF_INIT0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                E,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                mem_write,
    input  logic                mem_read,
    input  logic                clear,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                addr_err,
    output logic                ready
);
    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    // Range check is done one bit wider than either operand so DEPTH never truncates.
    localparam int CMP_W = (ADDR_W > 32 ? ADDR_W : 32) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              aerr_q, aerr_d;
    logic [DATA_W-1:0] old_word, merged, acc_word;
    logic [CW-1:0]     idx;
    logic              acc, in_range, wr_en;

    assign in_range = CMP_W'(address) < CMP_W'(DEPTH);
    assign idx      = CW'(address);
    assign acc      = state_q == READY && E && !clear;
    assign old_word = mem[idx];
    assign acc_word = mem_write ? merged : old_word;

    dm_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_i   (old_word),
        .wdata_i (write_data),
        .be_i    (byte_en),
        .new_o   (merged)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST) state_d = READY;
        end else if (clear) begin
            state_d = CLEAR;
        end
        cnt_d    = state_q == CLEAR && cnt_q != LAST ? cnt_q + 1'b1 : '0;
        wr_en    = acc && mem_write && in_range;
        rvalid_d = acc && mem_read;
        aerr_d   = acc ? !in_range : aerr_q;
        rdata_d  = rvalid_d ? (in_range ? acc_word : '0) : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
        end
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == CLEAR)
            mem[cnt_q] <= cnt_q == '0 ? DATA_W'(INIT0) : '0;
        else if (wr_en)
            mem[idx] <= merged;
    end

    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;
    assign addr_err   = aerr_q;
    assign ready      = state_q == READY;
endmodule

// File: tb/tb_data_memory_param.sv
// tb_data_memory_param: scoreboard-driven bench for data_memory_param at DEPTH=16.
module tb_data_memory_param;
    localparam int DW  = 64;
    localparam int DEP = 16;
    localparam int AW  = 64;

    logic            clk = 1'b0, rst_n = 1'b0, E = 1'b0;
    logic            mem_write = 1'b0, mem_read = 1'b0, clear = 1'b0;
    logic [AW-1:0]   address = '0;
    logic [DW-1:0]   write_data = '0;
    logic [DW/8-1:0] byte_en = '0;
    logic [DW-1:0]   read_data;
    logic            read_valid, addr_err, ready;

    logic [DW-1:0] mem_m [DEP];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_memory_param #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .INIT0(53)) dut (
        .clk(clk), .rst_n(rst_n), .E(E), .address(address), .write_data(write_data),
        .byte_en(byte_en), .mem_write(mem_write), .mem_read(mem_read), .clear(clear),
        .read_data(read_data), .read_valid(read_valid), .addr_err(addr_err), .ready(ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, we, re, cl, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        E = e; mem_write = we; mem_read = re; clear = cl;
        address = a; write_data = d; byte_en = be;
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic model_sweep;
        foreach (mem_m[i]) mem_m[i] = '0;
        mem_m[0] = 64'd53;
    endtask

    task automatic model_write(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        for (int b = 0; b < DW / 8; b++)
            if (be[b]) mem_m[a][8*b+:8] = d[8*b+:8];
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            if (n == 5) idle;
            tick;
            n++;
        end
        checks++;
        if (n != DEP) begin
            errors++;
            $display("FAIL %s sweep_cycles got %0d want %0d", name, n, DEP);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++; if (read_data !== '0) begin errors++; $display("FAIL rst_rdata got %h want 0", read_data); end
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", read_valid); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_aerr got %b want 0", addr_err); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reset_release");
        model_sweep;
        for (int a = 0; a < 6; a += 5) begin
            drive(1, 0, 1, 0, a, '0, '0);
            exp_q.push_back(mem_m[a]);
            tick;
            checks++;
            if (read_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL init_read%0d read_valid got %b want 1", a, read_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (read_data !== exp) begin errors++; $display("FAIL init_read%0d got %h want %h", a, read_data, exp); end
            end
        end
        idle;
    endtask

    task automatic test_byte_en;
        drive(1, 1, 0, 0, 3, 64'h1122334455667788, 8'hFF);
        model_write(3, 64'h1122334455667788, 8'hFF);
        tick;
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL write_rvalid got %b want 0", read_valid); end
        drive(1, 1, 0, 0, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        model_write(3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        tick;
        drive(1, 0, 1, 0, 3, '0, '0);
        exp_q.push_back(mem_m[3]);
        tick;
        idle;
        checks++;
        if (read_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL byte_en read_valid got %b want 1", read_valid);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (read_data !== exp || read_data !== 64'h11223344AAAAAAAA) begin
                errors++; $display("FAIL byte_en got %h want %h", read_data, exp);
            end
        end
        tick;
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b want 0", read_valid); end
    endtask

    task automatic test_rw_same;
        logic [DW-1:0] wd [2] = '{64'hDEAD, 64'h1100};
        logic [7:0]    be [2] = '{8'hFF, 8'h02};
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 7, wd[i], be[i]);
            model_write(7, wd[i], be[i]);
            exp_q.push_back(mem_m[7]);
            tick;
            checks++;
            if (read_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL rw_same%0d read_valid got %b want 1", i, read_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (read_data !== exp) begin errors++; $display("FAIL rw_same%0d got %h want %h", i, read_data, exp); end
            end
        end
        idle;
    endtask

    task automatic test_hold;
        drive(0, 1, 1, 0, 7, '0, 8'hFF);
        tick;
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL hold_rvalid got %b want 0", read_valid); end
        checks++; if (read_data !== mem_m[7]) begin errors++; $display("FAIL hold_rdata got %h want %h", read_data, mem_m[7]); end
        idle;
    endtask

    task automatic test_addr_err;
        drive(1, 1, 0, 0, 16, '1, 8'hFF);
        tick;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL aerr16 got %b want 1", addr_err); end
        drive(1, 1, 0, 0, 64'h1_0000_0003, '1, 8'hFF);
        tick;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL aerr_wide got %b want 1", addr_err); end
        drive(1, 0, 1, 0, 20, '0, '0);
        exp_q.push_back('0);
        tick;
        checks++;
        if (read_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL oor_read read_valid got %b want 1", read_valid);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (read_data !== exp) begin errors++; $display("FAIL oor_read got %h want %h", read_data, exp); end
        end
        drive(1, 0, 1, 0, 3, '0, '0);
        exp_q.push_back(mem_m[3]);
        tick;
        idle;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL aerr_clear got %b want 0", addr_err); end
        checks++;
        if (read_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL aerr_read3 read_valid got %b want 1", read_valid);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (read_data !== exp) begin errors++; $display("FAIL aerr_read3 got %h want %h", read_data, exp); end
        end
    endtask

    task automatic test_back_to_back;
        for (int a = 8; a < 12; a++) begin
            logic [DW-1:0] d = {$urandom, $urandom};
            drive(1, 1, 0, 0, a, d, 8'hFF);
            model_write(a, d, 8'hFF);
            tick;
        end
        for (int a = 0; a < DEP; a++) begin
            drive(1, 0, 1, 0, a, '0, '0);
            exp_q.push_back(mem_m[a]);
            tick;
            checks++;
            if (read_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL b2b%0d read_valid got %b want 1", a, read_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (read_data !== exp) begin errors++; $display("FAIL b2b%0d got %h want %h", a, read_data, exp); end
            end
        end
        idle;
    endtask

    task automatic test_clear;
        drive(1, 1, 0, 1, 2, 64'd9, 8'hFF);
        tick;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b want 0", ready); end
        drive(0, 0, 0, 1, '0, '0, '0);
        wait_ready("clear_sweep");
        model_sweep;
        for (int a = 0; a < 3; a += 2) begin
            drive(1, 0, 1, 0, a, '0, '0);
            exp_q.push_back(mem_m[a]);
            tick;
            checks++;
            if (read_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL clear_read%0d read_valid got %b want 1", a, read_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (read_data !== exp) begin errors++; $display("FAIL clear_read%0d got %h want %h", a, read_data, exp); end
            end
        end
        idle;
    endtask

    task automatic test_reset_mid_sweep;
        drive(1, 0, 1, 0, 0, '0, '0);
        tick;
        drive(1, 1, 0, 0, 100, '1, 8'hFF);
        tick;
        checks++;
        if (read_data !== 64'd53 || addr_err !== 1'b1) begin
            errors++; $display("FAIL pre_rst got rdata=%h aerr=%b want 35/1", read_data, addr_err);
        end
        drive(0, 0, 0, 1, '0, '0, '0);
        tick;
        idle;
        repeat (8) tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (read_data !== '0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", read_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mid_rst_aerr got %b want 0", addr_err); end
        checks++; if (ready !== 1'b0 || read_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready got ready=%b rvalid=%b want 0/0", ready, read_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("mid_rst_sweep");
        model_sweep;
        drive(1, 0, 1, 0, 0, '0, '0);
        exp_q.push_back(mem_m[0]);
        tick;
        idle;
        checks++;
        if (read_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL post_rst_read read_valid got %b want 1", read_valid);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (read_data !== exp) begin errors++; $display("FAIL post_rst_read got %h want %h", read_data, exp); end
        end
    endtask

    initial begin
        test_reset;
        test_byte_en;
        test_rw_same;
        test_hold;
        test_addr_err;
        test_back_to_back;
        test_clear;
        test_reset_mid_sweep;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
